// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: word-addressed backing store behind the cache.
// A request is taken in IDLE and held in ACCESS for a programmable number of
// cycles. The array access happens on the last ACCESS edge, and completion is
// reported by a one-cycle mem_ready pulse from DONE. Saturating counters
// record how many reads and writes have completed.
module main_mem_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // The down-counter starts at LAT-1, so the array access lands LAT edges
    // after the accept edge.
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Main-memory array. Reset leaves it alone. It is named mem so that the
    // bench can reach into it as a backdoor.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [3:0]            lat_cnt_reg;
    logic [3:0]            lat_cnt_next;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    logic accept;
    logic access_end;
    logic done;

    assign accept     = (state_reg == ST_IDLE) && mem_req;
    assign access_end = (state_reg == ST_ACCESS) && (lat_cnt_reg == 4'd0);
    assign done       = (state_reg == ST_DONE);

    // Next-state logic and the latency down-counter.
    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_req) begin
                    state_next   = ST_ACCESS;
                    lat_cnt_next = mem_we ? WR_LOAD : RD_LOAD;
                end
            end
            ST_ACCESS: begin
                if (lat_cnt_reg == 4'd0) begin
                    state_next = ST_DONE;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 4'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next   = ST_IDLE;
                lat_cnt_next = 4'd0;
            end
        endcase
    end

    // Control state: FSM, latched request, status outputs and the read data
    // register. A reset mid-request drops it cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            lat_cnt_reg <= 4'd0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            mem_ready   <= 1'b0;
            mem_busy    <= 1'b0;
            mem_rdata   <= '0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            mem_ready   <= access_end;
            mem_busy    <= (state_next != ST_IDLE);
            if (accept) begin
                we_reg    <= mem_we;
                addr_reg  <= mem_addr;
                wdata_reg <= mem_wdata;
            end
            if (access_end && !we_reg) begin
                mem_rdata <= mem[addr_reg];
            end
        end
    end

    // Array write port. It is gated by the FSM state, so a reset during
    // ACCESS suppresses the commit.
    always_ff @(posedge clk) begin
        if (access_end && we_reg) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    // Completion counters advance on the DONE->IDLE edge and stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (done) begin
            if (we_reg) begin
                if (wr_count != CNT_MAX) begin
                    wr_count <= wr_count + 1'b1;
                end
            end else begin
                if (rd_count != CNT_MAX) begin
                    rd_count <= rd_count + 1'b1;
                end
            end
        end
    end

endmodule
